// File: rtl/mem_dump_engine_if.sv
// Command, shared read port and output stream of the memory dump engine.
// The slave side is the engine; the master side is the host, memory mux and stream sink.
interface mem_dump_engine_if #(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic              start;
   logic              abort;
   logic [NUM_CH-1:0] ch_mask;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [CH_W-1:0]   rd_ch;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CH_W-1:0]   out_ch;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic [31:0]       out_sum;

   modport slave (
      input  start, abort, ch_mask, rd_data, out_ready,
      output busy, done, rd_en, rd_ch, rd_addr,
      output out_valid, out_data, out_ch, out_addr, out_last, out_sum
   );

   modport master (
      output start, abort, ch_mask, rd_data, out_ready,
      input  busy, done, rd_en, rd_ch, rd_addr,
      input  out_valid, out_data, out_ch, out_addr, out_last, out_sum
   );
endinterface

// File: rtl/mem_dump_engine.sv
// Walks the enabled memory channels through one shared read port and streams
// every word, tagged with channel/address, while accumulating a 32-bit checksum.
module mem_dump_engine #(
   parameter int                        NUM_CH     = 3,
   parameter int                        ADDR_W     = 8,
   parameter int                        DATA_W     = 32,
   parameter int                        RD_LATENCY = 1,
   parameter logic [NUM_CH*ADDR_W-1:0]  CH_LAST    = {8'd63, 8'd255, 8'd255}
) (
   input  logic                 clk_25mhz,
   input  logic                 reset,
   mem_dump_engine_if.slave     bus
);
   localparam int         CH_W       = $clog2(NUM_CH) + 1;
   localparam int         MASK_EXT_W = 2 ** CH_W;
   localparam logic [1:0] LAT_LAST   = 2'(RD_LATENCY - 1);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_RD, S_WAIT, S_SEND, S_DONE} state_t;

   state_t            r_state, w_state_next;
   logic [CH_W-1:0]   r_ch, w_ch_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [NUM_CH-1:0] r_mask, w_mask_next;
   logic [31:0]       r_sum, w_sum_next;
   logic [1:0]        r_wait, w_wait_next;
   logic [DATA_W-1:0] r_out_data, w_out_data_next;
   logic [CH_W-1:0]   r_out_ch, w_out_ch_next;
   logic [ADDR_W-1:0] r_out_addr, w_out_addr_next;
   logic              r_out_last, w_out_last_next;

   logic                  w_busy, w_done, w_rd_en, w_out_valid, w_last_ch;
   logic [MASK_EXT_W-1:0] w_mask_ext;
   logic [ADDR_W-1:0]     w_ch_last [MASK_EXT_W];

   // Lookup table padded to a power of two so the channel counter indexes it directly
   genvar gi;
   generate
      for (gi = 0; gi < MASK_EXT_W; gi++) begin : g_last
         if (gi < NUM_CH) begin : g_used
            assign w_ch_last[gi] = CH_LAST[gi*ADDR_W +: ADDR_W];
         end else begin : g_pad
            assign w_ch_last[gi] = '0;
         end
      end
   endgenerate

   assign w_mask_ext = MASK_EXT_W'(r_mask);
   assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ch       <= '0;
         r_addr     <= '0;
         r_mask     <= '0;
         r_sum      <= '0;
         r_wait     <= '0;
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_out_addr <= '0;
         r_out_last <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ch       <= w_ch_next;
         r_addr     <= w_addr_next;
         r_mask     <= w_mask_next;
         r_sum      <= w_sum_next;
         r_wait     <= w_wait_next;
         r_out_data <= w_out_data_next;
         r_out_ch   <= w_out_ch_next;
         r_out_addr <= w_out_addr_next;
         r_out_last <= w_out_last_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_ch_next       = r_ch;
      w_addr_next     = r_addr;
      w_mask_next     = r_mask;
      w_sum_next      = r_sum;
      w_wait_next     = r_wait;
      w_out_data_next = r_out_data;
      w_out_ch_next   = r_out_ch;
      w_out_addr_next = r_out_addr;
      w_out_last_next = r_out_last;
      w_busy          = (r_state != S_IDLE);
      w_done          = 1'b0;
      w_rd_en         = 1'b0;
      w_out_valid     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_mask_next  = bus.ch_mask;
               w_sum_next   = '0;
               w_ch_next    = '0;
               w_addr_next  = '0;
               w_state_next = S_SCAN;
            end
         end
         S_SCAN: begin
            if (w_mask_ext[r_ch]) begin
               w_addr_next  = '0;
               w_state_next = S_RD;
            end else if (w_last_ch) begin
               w_state_next = S_DONE;
            end else begin
               w_ch_next = r_ch + CH_W'(1);
            end
         end
         S_RD: begin
            w_rd_en      = 1'b1;
            w_wait_next  = '0;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (r_wait == LAT_LAST) begin
               w_out_data_next = bus.rd_data;
               w_out_ch_next   = r_ch;
               w_out_addr_next = r_addr;
               w_out_last_next = (r_addr == w_ch_last[r_ch]);
               w_state_next    = S_SEND;
            end else begin
               w_wait_next = r_wait + 2'd1;
            end
         end
         S_SEND: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_sum_next = r_sum + 32'(r_out_data);
               if (r_addr < w_ch_last[r_ch]) begin
                  w_addr_next  = r_addr + ADDR_W'(1);
                  w_state_next = S_RD;
               end else if (w_last_ch) begin
                  w_state_next = S_DONE;
               end else begin
                  w_ch_next    = r_ch + CH_W'(1);
                  w_state_next = S_SCAN;
               end
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase

      // Abort wins over everything and throws away the partial checksum
      if (bus.abort && r_state != S_IDLE) begin
         w_state_next = S_IDLE;
         w_sum_next   = '0;
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_ch     = r_ch;
   assign bus.rd_addr   = r_addr;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_last  = r_out_last;
   assign bus.out_sum   = r_sum;
endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: 3 channels with last addresses 3/1/2 and a
// one-cycle-latency memory returning ch*256+addr.
module tb_mem_dump_engine;
   logic clk = 1'b0;
   logic reset;
   always #20 clk = ~clk;

   mem_dump_engine_if #(.NUM_CH(3), .ADDR_W(8), .DATA_W(32)) bus ();

   mem_dump_engine #(
      .NUM_CH(3), .ADDR_W(8), .DATA_W(32), .RD_LATENCY(1),
      .CH_LAST({8'd2, 8'd1, 8'd3})
   ) dut (
      .clk_25mhz(clk),
      .reset(reset),
      .bus(bus)
   );

   always @(posedge clk)
      if (bus.rd_en === 1'b1)
         bus.rd_data <= 32'(bus.rd_ch) * 32'd256 + 32'(bus.rd_addr);

   int          n_vec = 0;
   int          n_err = 0;
   int          n_cap = 0;
   int          done_cnt = 0;
   int          rd_cnt = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          done_cyc = 0;
   logic [31:0] done_sum = '0;
   logic [31:0] cap_data [32];
   logic [2:0]  cap_ch   [32];
   logic [7:0]  cap_addr [32];
   logic        cap_last [32];
   int          cap_cyc  [32];

   always @(posedge clk) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (n_cap < 32) begin
            cap_data[n_cap] <= bus.out_data;
            cap_ch[n_cap]   <= bus.out_ch;
            cap_addr[n_cap] <= bus.out_addr;
            cap_last[n_cap] <= bus.out_last;
            cap_cyc[n_cap]  <= cyc;
         end
         n_cap <= n_cap + 1;
         $display("word %0d: ch=%0d addr=%0d data=%08h last=%0d", n_cap, bus.out_ch,
                  bus.out_addr, bus.out_data, bus.out_last);
      end
      if (bus.done === 1'b1) begin
         done_cnt <= done_cnt + 1;
         done_sum <= bus.out_sum;
         done_cyc <= cyc;
      end
      if (bus.rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
      if (bus.start === 1'b1 && bus.busy === 1'b0 && reset === 1'b0) start_cyc <= cyc;
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_cap();
      @(negedge clk);
      n_cap = 0; done_cnt = 0; rd_cnt = 0;
   endtask

   task automatic do_start(input logic [2:0] m);
      @(negedge clk);
      bus.start = 1'b1; bus.ch_mask = m;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done_cnt == 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_word(input string tag, input logic [2:0] ch, input logic [7:0] addr);
      int k = 0;
      while (!(bus.out_valid === 1'b1 && bus.out_ch == ch && bus.out_addr == addr) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_word_seen"}, 64'(k < 300), 64'd1);
   endtask

   task automatic check_dump(input string tag, input logic [2:0] mask, input logic [31:0] exp_sum);
      int last_of [3] = '{3, 1, 2};
      int i = 0;
      for (int c = 0; c < 3; c++) begin
         if (mask[c]) begin
            for (int a = 0; a <= last_of[c]; a++) begin
               if (i < 32) begin
                  check($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]), 64'(c * 256 + a));
                  check($sformatf("%s_ch%0d", tag, i), 64'(cap_ch[i]), 64'(c));
                  check($sformatf("%s_addr%0d", tag, i), 64'(cap_addr[i]), 64'(a));
                  check($sformatf("%s_last%0d", tag, i), 64'(cap_last[i]), 64'(a == last_of[c]));
                  if (a > 0)
                     check($sformatf("%s_gap%0d", tag, i), 64'(cap_cyc[i] - cap_cyc[i-1]), 64'd3);
               end
               i++;
            end
         end
      end
      check({tag, "_count"}, 64'(n_cap), 64'(i));
      check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
      check({tag, "_done_sum"}, 64'(done_sum), 64'(exp_sum));
      check({tag, "_sum_held"}, 64'(bus.out_sum), 64'(exp_sum));
   endtask

   initial begin
      logic [31:0] hold_data;
      bit          stable;
      int          base_cap;
      int          base_rd;

      // 1: reset held with start pulsed -> nothing happens
      reset = 1'b1;
      bus.start = 1'b1; bus.abort = 1'b0; bus.ch_mask = 3'b111; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_rd_en", 64'(bus.rd_en), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sum", 64'(bus.out_sum), 64'd0);
      check("rst_data", 64'(bus.out_data), 64'd0);
      check("rst_addr", 64'(bus.rd_addr), 64'd0);
      check("rst_last", 64'(bus.out_last), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_no_words", 64'(n_cap), 64'd0);
      check("rst_no_reads", 64'(rd_cnt), 64'd0);
      check("rst_idle_after", 64'(bus.busy), 64'd0);

      // 2: full dump, sink always ready
      clear_cap();
      do_start(3'b111);
      check("t2_busy", 64'(bus.busy), 64'd1);
      wait_done("t2");
      check_dump("t2", 3'b111, 32'h80A);
      check("t2_rd_count", 64'(rd_cnt), 64'd9);

      // 3: stall the sink for 5 cycles on word (1,0)
      clear_cap();
      do_start(3'b111);
      wait_word("t3", 3'd1, 8'd0);
      bus.out_ready = 1'b0;
      hold_data = bus.out_data;
      base_rd = rd_cnt;
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (!(bus.out_valid === 1'b1 && bus.out_data === hold_data && bus.out_ch === 3'd1 &&
               bus.out_addr === 8'd0 && bus.out_last === 1'b0 && bus.rd_en === 1'b0))
            stable = 1'b0;
      end
      check("t3_held_data", 64'(hold_data), 64'h100);
      check("t3_stable", 64'(stable), 64'd1);
      check("t3_no_rd", 64'(rd_cnt - base_rd), 64'd0);
      bus.out_ready = 1'b1;
      wait_done("t3");
      check_dump("t3", 3'b111, 32'h80A);

      // 4: single channel, with ch_mask changed after start
      clear_cap();
      do_start(3'b010);
      bus.ch_mask = 3'b111;
      wait_done("t4a");
      check_dump("t4a", 3'b010, 32'h201);

      clear_cap();
      do_start(3'b000);
      wait_done("t4b");
      check("t4b_words", 64'(n_cap), 64'd0);
      check("t4b_done_cycle", 64'(done_cyc - start_cyc), 64'd4);
      check("t4b_sum", 64'(done_sum), 64'd0);
      check("t4b_done_once", 64'(done_cnt), 64'd1);

      // 5: abort during SEND of (0,2), then an ignored restart while busy
      clear_cap();
      do_start(3'b111);
      wait_word("t5", 3'd0, 8'd2);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("t5_valid_drop", 64'(bus.out_valid), 64'd0);
      check("t5_busy_drop", 64'(bus.busy), 64'd0);
      check("t5_sum_cleared", 64'(bus.out_sum), 64'd0);
      repeat (10) @(negedge clk);
      check("t5_no_done", 64'(done_cnt), 64'd0);
      check("t5_stays_idle", 64'(bus.busy), 64'd0);

      clear_cap();
      do_start(3'b111);
      repeat (6) @(negedge clk);
      do_start(3'b001);
      bus.ch_mask = 3'b111;
      wait_done("t5b");
      check_dump("t5b", 3'b111, 32'h80A);

      // 6: reset in the middle of a dump
      clear_cap();
      do_start(3'b111);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6_busy", 64'(bus.busy), 64'd0);
      check("t6_valid", 64'(bus.out_valid), 64'd0);
      check("t6_rd_en", 64'(bus.rd_en), 64'd0);
      check("t6_sum", 64'(bus.out_sum), 64'd0);
      check("t6_data", 64'(bus.out_data), 64'd0);
      check("t6_out_ch", 64'(bus.out_ch), 64'd0);
      reset = 1'b0;
      base_cap = n_cap;
      base_rd = rd_cnt;
      repeat (20) @(negedge clk);
      check("t6_no_done", 64'(done_cnt), 64'd0);
      check("t6_no_words", 64'(n_cap - base_cap), 64'd0);
      check("t6_no_reads", 64'(rd_cnt - base_rd), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
